// File: rtl/aes_inv_key_sched.sv
// aes_inv_key_sched: inverse AES-128-style key schedule, emits round keys NR..0 one per handshake (optional AES_KEY_ZEROIZE_EN).
// Latency: first key 1 cycle after start, then one key per accepted beat; done pulses 1 cycle after the round-0 beat.
// Backpressure: rk_out/rk_round held while rk_valid & !rk_ready; valid only drops on the final beat or abort.

module aes_rcon (
  input  logic [3:0] idx,
  output logic [7:0] rcon
);
  always_comb begin
    rcon = 8'h00;
    case (idx)
      4'd0:  rcon = 8'h01;
      4'd1:  rcon = 8'h02;
      4'd2:  rcon = 8'h04;
      4'd3:  rcon = 8'h08;
      4'd4:  rcon = 8'h10;
      4'd5:  rcon = 8'h20;
      4'd6:  rcon = 8'h40;
      4'd7:  rcon = 8'h80;
      4'd8:  rcon = 8'h1b;
      4'd9:  rcon = 8'h36;
      4'd10: rcon = 8'h6c;
      4'd11: rcon = 8'hd8;
      4'd12: rcon = 8'hab;
      4'd13: rcon = 8'h4d;
      4'd14: rcon = 8'h9a;
      default: rcon = 8'h00;
    endcase
  end
endmodule

module aes_inv_key_sched #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         abort,
  input  logic         rk_ready,
  output logic         rk_valid,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         busy,
  output logic         done
);

`ifdef AES_KEY_ZEROIZE_EN
  localparam bit ZEROIZE = 1'b1;
`else
  localparam bit ZEROIZE = 1'b0;
`endif

  typedef enum logic {IDLE, EMIT} state_t;

  state_t       state, state_d;
  logic [127:0] key_d, prev_key;
  logic [3:0]   round_d, rcon_idx;
  logic         done_d, beat;
  logic [31:0]  w0, w1, w2, w3, p0, p1, p2, p3, rot, sub;
  logic [7:0]   rcon;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Forward S-box: multiplicative inverse as x^254, then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      inv = gf_mul(inv, inv);
      if (i != 0) inv = gf_mul(inv, x);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  assign {w0, w1, w2, w3} = rk_out;
  assign p3  = w3 ^ w2;
  assign p2  = w2 ^ w1;
  assign p1  = w1 ^ w0;
  assign rot = {p3[23:0], p3[31:24]};
  assign sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
  assign rcon_idx = rk_round - 4'd1;

  aes_rcon u_rcon (
    .idx  (rcon_idx),
    .rcon (rcon)
  );

  assign p0       = w0 ^ sub ^ {rcon, 24'h000000};
  assign prev_key = {p0, p1, p2, p3};

  assign rk_valid = (state == EMIT);
  assign busy     = (state == EMIT);
  assign beat     = rk_valid & rk_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    key_d   = rk_out;
    round_d = rk_round;
    done_d  = 1'b0;
    if (abort) begin
      // abort beats everything, including a coincident start or final beat
      state_d = IDLE;
      if (ZEROIZE) begin
        key_d   = '0;
        round_d = '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_d = EMIT;
            key_d   = key_in;
            round_d = 4'(NR);
          end
        end
        EMIT: begin
          if (beat) begin
            if (rk_round != 4'd0) begin
              key_d   = prev_key;
              round_d = rk_round - 4'd1;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
              if (ZEROIZE) begin
                key_d   = '0;
                round_d = '0;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_out   <= '0;
      rk_round <= '0;
      done     <= 1'b0;
    end else begin
      rk_out   <= key_d;
      rk_round <= round_d;
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Bench for aes_inv_key_sched: cycle model of the handshake plus FIPS-197 A.1 literal round keys; second instance at NR=14.
module tb_aes_inv_key_sched;
  localparam int NR = 10;
  localparam logic [127:0] K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, start, abort, rk_ready, rk_valid, busy, done;
  logic [127:0] key_in, rk_out;
  logic [3:0]   rk_round;

  logic         s_start, s_abort, s_ready, s_valid, s_busy, s_done;
  logic [127:0] s_key, s_out;
  logic [3:0]   s_round;

  aes_inv_key_sched #(.NR(NR)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .abort(abort),
    .rk_ready(rk_ready), .rk_valid(rk_valid), .rk_out(rk_out), .rk_round(rk_round),
    .busy(busy), .done(done)
  );

  aes_inv_key_sched #(.NR(14)) u_dut14 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .key_in(s_key), .abort(s_abort),
    .rk_ready(s_ready), .rk_valid(s_valid), .rk_out(s_out), .rk_round(s_round),
    .busy(s_busy), .done(s_done)
  );

  int tests = 0;
  int fails = 0;
  logic [7:0] sbox_t[256];
  logic [7:0] rcon_t[16];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_tables();
    logic [7:0] inv, s, c, r;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (tb_gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_t[x] = s;
    end
    r = 8'h01;
    for (int i = 0; i < 16; i++) begin
      rcon_t[i] = r;
      r = tb_gmul(r, 8'h02);
    end
  endtask

  // Key of round rnd-1 from the key of round rnd.
  function automatic logic [127:0] prev_key(input logic [127:0] k, input int rnd);
    logic [31:0] w[4];
    logic [31:0] n[4];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    n[3] = w[3] ^ w[2];
    n[2] = w[2] ^ w[1];
    n[1] = w[1] ^ w[0];
    t = {n[3][23:0], n[3][31:24]};
    t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
    n[0] = w[0] ^ t ^ {rcon_t[rnd-1], 24'h0};
    return {n[0], n[1], n[2], n[3]};
  endfunction

  typedef struct {
    logic [127:0] k;
    logic [3:0]   r;
  } ent_t;

  ent_t         q[$];
  logic         m_busy = 1'b0, m_done = 1'b0;
  logic [127:0] m_hold_k = '0;
  logic [3:0]   m_hold_r = '0;
  int           beats = 0, done_cnt = 0;
  logic [127:0] acc[16];

  always @(negedge clk) begin
    logic   was_busy;
    logic   fin;
    logic [127:0] k;
    ent_t   e;
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; q.delete(); m_hold_k = '0; m_hold_r = '0;
    end else begin
      chk("rk_valid", 128'(rk_valid), 128'(m_busy));
      chk("busy", 128'(busy), 128'(m_busy));
      chk("done", 128'(done), 128'(m_done));
      if (m_busy) begin
        chk("rk_out", rk_out, q[0].k);
        chk("rk_round", 128'(rk_round), 128'(q[0].r));
      end else begin
        chk("idle_rk_out", rk_out, m_hold_k);
        chk("idle_rk_round", 128'(rk_round), 128'(m_hold_r));
      end
      if (done) done_cnt++;
      was_busy = m_busy;
      fin = 1'b0;
      m_done = 1'b0;
      if (was_busy) begin
        m_hold_k = q[0].k;
        m_hold_r = q[0].r;
        if (rk_ready) begin
          beats++;
          acc[rk_round] = rk_out;
          e = q.pop_front();
          if (q.size() == 0) fin = 1'b1;
        end
      end
      if (abort) begin
        m_busy = 1'b0;
        q.delete();
`ifdef AES_KEY_ZEROIZE_EN
        m_hold_k = '0; m_hold_r = '0;
`endif
      end else if (fin) begin
        m_busy = 1'b0;
        m_done = 1'b1;
`ifdef AES_KEY_ZEROIZE_EN
        m_hold_k = '0; m_hold_r = '0;
`endif
      end else if (!was_busy && start) begin
        k = key_in;
        for (int r = NR; r >= 0; r--) begin
          q.push_back('{k: k, r: 4'(r)});
          if (r > 0) k = prev_key(k, r);
        end
        m_busy = 1'b1;
      end
    end
  end

  task automatic kick(input logic [127:0] k);
    key_in = k;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  task automatic run_until_done(input string name, input int budget, input bit rnd);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (rnd) rk_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (done) begin seen = 1'b1; break; end
    end
    rk_ready = 1'b1;
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL %s_done: done not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_round(input string name, input logic [3:0] r, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (rk_valid && rk_round == r) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL %s_wait: round %0d not seen within %0d cycles", name, r, budget);
    end
  endtask

  task automatic clear_log();
    beats = 0;
    done_cnt = 0;
    for (int i = 0; i < 16; i++) acc[i] = '0;
  endtask

  initial begin
    logic [127:0] k;
    int n;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; rk_ready = 1'b0; key_in = '0;
    s_start = 1'b0; s_abort = 1'b0; s_ready = 1'b0; s_key = '0;
    build_tables();

    // the model itself must reproduce FIPS-197 A.1
    k = K10;
    for (int r = 10; r > 0; r--) begin
      k = prev_key(k, r);
      if (r == 10) chk("model_round9", k, K9);
    end
    chk("model_round0", k, K0);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_rk_valid", 128'(rk_valid), 128'(0));
    chk("reset_rk_out", rk_out, 128'(0));
    chk("reset_rk_round", 128'(rk_round), 128'(0));

    // 1: full throughput
    clear_log();
    rk_ready = 1'b1;
    kick(K10);
    chk("t1_first_round", 128'(rk_round), 128'(10));
    chk("t1_first_key", rk_out, K10);
    run_until_done("t1", 100, 1'b0);
    chk("t1_beats", 128'(beats), 128'(11));
    chk("t1_round10", acc[10], K10);
    chk("t1_round9", acc[9], K9);
    chk("t1_round0", acc[0], K0);

    // 2: random backpressure
    repeat (2) @(posedge clk); #1;
    clear_log();
    kick(K10);
    run_until_done("t2", 600, 1'b1);
    chk("t2_beats", 128'(beats), 128'(11));
    chk("t2_round9", acc[9], K9);
    chk("t2_round0", acc[0], K0);

    // 3: abort right after the round-7 beat, then restart
    repeat (2) @(posedge clk); #1;
    clear_log();
    kick(K10);
    wait_round("t3", 4'd7, 50);
    @(posedge clk); #1;
    abort = 1'b1;
    rk_ready = 1'b0;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("t3_valid_after_abort", 128'(rk_valid), 128'(0));
    repeat (3) @(posedge clk); #1;
    chk("t3_no_done", 128'(done_cnt), 128'(0));
    rk_ready = 1'b1;
    kick(K10);
    chk("t3_restart_round", 128'(rk_round), 128'(10));
    chk("t3_restart_key", rk_out, K10);
    run_until_done("t3", 100, 1'b0);
    chk("t3_round0", acc[0], K0);

    // 4: start with another key mid-schedule is ignored
    repeat (2) @(posedge clk); #1;
    clear_log();
    kick(K10);
    repeat (3) @(posedge clk); #1;
    key_in = 128'h00112233445566778899aabbccddeeff;
    start  = 1'b1;
    repeat (2) @(posedge clk); #1;
    start  = 1'b0;
    run_until_done("t4", 100, 1'b0);
    chk("t4_beats", 128'(beats), 128'(11));
    chk("t4_round0", acc[0], K0);

    // 5: asynchronous reset mid-schedule
    repeat (2) @(posedge clk); #1;
    clear_log();
    kick(K10);
    wait_round("t5", 4'd5, 50);
    rk_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 128'(rk_valid), 128'(0));
    chk("t5_rst_out", rk_out, 128'(0));
    chk("t5_rst_round", 128'(rk_round), 128'(0));
    chk("t5_rst_busy", 128'(busy), 128'(0));
    chk("t5_rst_done", 128'(done), 128'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    clear_log();
    rk_ready = 1'b1;
    kick(K10);
    run_until_done("t5", 100, 1'b0);
    chk("t5_beats", 128'(beats), 128'(11));
    chk("t5_round0", acc[0], K0);

    // 6: NR=14 instance
    k = 128'h603deb1015ca71be2b73aef0857d7781;
    s_key = k;
    s_ready = 1'b1;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (s_done) break;
      if (s_valid) begin
        chk("t6_round", 128'(s_round), 128'(14 - n));
        chk("t6_key", s_out, k);
        if (n < 14) k = prev_key(k, 14 - n);
        n++;
      end
      @(posedge clk); #1;
    end
    chk("t6_beats", 128'(n), 128'(15));
    chk("t6_done", 128'(s_done), 128'(1));
    chk("t6_valid_after", 128'(s_valid), 128'(0));
`ifdef AES_KEY_ZEROIZE_EN
    chk("t6_zeroized_out", s_out, 128'(0));
    chk("t6_zeroized_round", 128'(s_round), 128'(0));
`else
    chk("t6_held_out", s_out, k);
    chk("t6_held_round", 128'(s_round), 128'(0));
`endif

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
